// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style control unit for a multicycle 32-bit ARM-like CPU. Decodes the
//   latched instruction, steps it through the multicycle state sequence, keeps
//   the architectural NZCV flag register and gates every state-changing write
//   with the condition result latched at the end of DECODE (cond_q).
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   Instr       in   [31:12] instruction register contents
//   ALUflags    in   [3:0] datapath flags {C,V,N,Z} = bits {3,2,1,0}
//   PCWrite     out  PC load enable
//   IRWrite     out  instruction register load enable
//   MemWrite    out  data memory write enable
//   RegWrite    out  register file write enable
//   AdrSrc      out  memory address select (0=PC, 1=ALUOut)
//   ALUSrcA     out  SrcA select (0=rd1, 1=PC)
//   ALUSrcB     out  [1:0] SrcB select (00=rd2, 01=ExtImm, 10=4)
//   ResultSrc   out  [1:0] result select (00=ALUOut, 01=read data, 10=ALU)
//   ImmSrc      out  [1:0] immediate format, Instr[27:26]
//   RegSrc      out  [1:0] [0]=branch reads R15, [1]=store reads Rd
//   ALUcontrol  out  [1:0] 00=ADD, 01=SUB, 10=AND, 11=ORR
//   State       out  [3:0] current FSM state (debug)
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:12] Instr,
   input  logic [3:0]  ALUflags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUcontrol,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic       cond_q;
   logic [3:0] flags_q;

   // Instruction fields
   logic [3:0] cond;
   logic [1:0] op;
   logic       i_bit;
   logic [3:0] cmd;
   logic       s_bit;
   logic       rd_is_pc;

   assign cond     = Instr[31:28];
   assign op       = Instr[27:26];
   assign i_bit    = Instr[25];
   assign cmd      = Instr[24:21];
   assign s_bit    = Instr[20];
   assign rd_is_pc = (Instr[15:12] == 4'hF);

   // Rn is consumed by the datapath only.
   logic unused_rn;
   assign unused_rn = ^Instr[19:16];

   // Data-processing decode
   logic       supported;
   logic       no_write;
   logic       cv_update;
   logic [1:0] dec_alu;

   always_comb begin
      supported = 1'b1;
      no_write  = 1'b0;
      cv_update = 1'b1;
      dec_alu   = 2'b00;
      case (cmd)
         4'b0100: dec_alu = 2'b00;                      // ADD
         4'b0010: dec_alu = 2'b01;                      // SUB
         4'b0000: begin dec_alu = 2'b10; cv_update = 1'b0; end  // AND
         4'b1100: begin dec_alu = 2'b11; cv_update = 1'b0; end  // ORR
         4'b1010: begin dec_alu = 2'b01; no_write = 1'b1; end   // CMP
         default: begin supported = 1'b0; cv_update = 1'b0; end
      endcase
   end

   // Condition evaluation on the architectural flags
   logic flag_z, flag_n, flag_v, flag_c, cond_ok;
   assign flag_z = flags_q[0];
   assign flag_n = flags_q[1];
   assign flag_v = flags_q[2];
   assign flag_c = flags_q[3];

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'h0: cond_ok = flag_z;
         4'h1: cond_ok = ~flag_z;
         4'h2: cond_ok = flag_c;
         4'h3: cond_ok = ~flag_c;
         4'h4: cond_ok = flag_n;
         4'h5: cond_ok = ~flag_n;
         4'h6: cond_ok = flag_v;
         4'h7: cond_ok = ~flag_v;
         4'h8: cond_ok = flag_c & ~flag_z;
         4'h9: cond_ok = ~flag_c | flag_z;
         4'hA: cond_ok = (flag_n == flag_v);
         4'hB: cond_ok = (flag_n != flag_v);
         4'hC: cond_ok = ~flag_z & (flag_n == flag_v);
         4'hD: cond_ok = flag_z | (flag_n != flag_v);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // State, latched condition and flag register
   logic in_execute;
   assign in_execute = (state_q == S_EXECR) || (state_q == S_EXECI);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cond_q  <= 1'b0;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            cond_q <= cond_ok;
         if (in_execute && cond_q && s_bit && supported) begin
            flags_q[1:0] <= ALUflags[1:0];
            // Logical ops leave carry and overflow untouched.
            if (cv_update)
               flags_q[3:2] <= ALUflags[3:2];
         end
      end
   end

   // Next state and Moore outputs
   logic pc_write_s, ir_write_s, mem_write_s, reg_write_s;
   logic dp_write;
   assign dp_write = cond_q & ~no_write & supported;

   always_comb begin
      state_d     = S_FETCH;
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ResultSrc   = 2'b00;
      ALUcontrol  = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;  // undefined, retire silently
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = 2'b01;
            state_d = s_bit ? S_MEMRD : S_MEMWR;  // bit 20 is L for memory ops
         end
         S_MEMRD: begin
            AdrSrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc   = 2'b01;
            reg_write_s = cond_q;
            pc_write_s  = cond_q & rd_is_pc;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc      = 1'b1;
            mem_write_s = cond_q;
            state_d     = S_FETCH;
         end
         S_EXECR: begin
            ALUcontrol = dec_alu;
            state_d    = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUcontrol = dec_alu;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = dp_write;
            pc_write_s  = dp_write & rd_is_pc;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            pc_write_s = cond_q;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are held off for as long as reset is low so nothing is written
   // between reset assertion and the first clean FETCH.
   assign PCWrite  = pc_write_s  & reset;
   assign IRWrite  = ir_write_s  & reset;
   assign MemWrite = mem_write_s & reset;
   assign RegWrite = reg_write_s & reset;

   assign ImmSrc = op;
   assign RegSrc = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
   assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:12] Instr;
   logic [3:0]  ALUflags;
   logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUcontrol;
   logic [3:0]  State;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUflags   (ALUflags),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUcontrol (ALUcontrol),
      .State      (State)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q[$];

   // {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
   //  ALUSrcB, ResultSrc, ALUcontrol, RegSrc, ImmSrc}
   logic [19:0] act_w;
   assign act_w = {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ALUcontrol, RegSrc, ImmSrc};

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  fl;
      int          ncyc;
      logic [19:0] sts;   // state of cycle c in sts[4c+:4]
      logic [4:0]  pcw;   // bit c = PCWrite in cycle c
      logic [4:0]  rgw;
      logic [4:0]  mw;
      logic [1:0]  ac;    // ALUcontrol in the execute state
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] ins, input logic [3:0] fl, input int n,
                      input logic [19:0] sts, input logic [4:0] pcw,
                      input logic [4:0] rgw, input logic [4:0] mw, input logic [1:0] ac);
      vec_t v;
      v.instr = ins; v.fl = fl; v.ncyc = n; v.sts = sts;
      v.pcw = pcw; v.rgw = rgw; v.mw = mw; v.ac = ac;
      vecs.push_back(v);
   endtask

   // Per-state datapath selects from the state table; enables come from the vector.
   function automatic logic [19:0] build_exp(input logic [3:0] st, input logic pcw,
                                             input logic mw, input logic rw,
                                             input logic [1:0] aluc, input logic [31:0] ins);
      logic       adr, srca;
      logic [1:0] srcb, res, ac, rs;
      adr = 1'b0; srca = 1'b0; srcb = 2'b00; res = 2'b00; ac = 2'b00;
      case (st)
         4'd0, 4'd1: begin srca = 1'b1; srcb = 2'b10; res = 2'b10; end
         4'd2:       srcb = 2'b01;
         4'd3, 4'd5: adr = 1'b1;
         4'd4:       res = 2'b01;
         4'd6:       ac = aluc;
         4'd7:       begin srcb = 2'b01; ac = aluc; end
         4'd9:       begin srcb = 2'b01; res = 2'b10; end
         default:    ;
      endcase
      rs = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
      return {st, pcw, (st == 4'd0), mw, rw, adr, srca, srcb, res, ac, rs, ins[27:26]};
   endfunction

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver: called at the negedge that starts FETCH; returns at the next FETCH negedge
   task automatic run_vec(input vec_t v, input string name);
      Instr    = v.instr[31:12];
      ALUflags = v.fl;
      for (int c = 0; c < v.ncyc; c++)
         exp_q.push_back(build_exp(v.sts[4*c +: 4], v.pcw[c], v.mw[c], v.rgw[c], v.ac, v.instr));
      for (int c = 0; c < v.ncyc; c++) begin
         #1;
         check($sformatf("%s cyc%0d", name, c), act_w, exp_q.pop_front());
         @(negedge clk);
      end
   endtask

   initial begin
      // vector table
      add(32'hE2801005, 4'b0000, 4, 20'h08710, 5'b00001, 5'b01000, 5'b0, 2'b00); // ADD imm
      add(32'hE3500000, 4'b0001, 4, 20'h08710, 5'b00001, 5'b00000, 5'b0, 2'b01); // CMP -> Z
      add(32'h0A000002, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BEQ taken
      add(32'h1A000002, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BNE not
      add(32'hE2900000, 4'b0000, 4, 20'h08710, 5'b00001, 5'b01000, 5'b0, 2'b00); // ADDS -> 0000
      add(32'h1A000002, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BNE taken
      add(32'hE2110000, 4'b1110, 4, 20'h08710, 5'b00001, 5'b01000, 5'b0, 2'b10); // ANDS -> N
      add(32'h4A000000, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BMI taken
      add(32'h2A000000, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BCS not (C held)
      add(32'h6A000000, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BVS not (V held)
      add(32'hBA000000, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BLT taken
      add(32'hCA000000, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BGT not
      add(32'hE2B01005, 4'b0001, 4, 20'h08710, 5'b00001, 5'b00000, 5'b0, 2'b00); // unsupported cmd
      add(32'h0A000002, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BEQ not
      add(32'hE3910000, 4'b0001, 4, 20'h08710, 5'b00001, 5'b01000, 5'b0, 2'b11); // ORRS -> Z
      add(32'h0A000002, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BEQ taken
      add(32'hE5912000, 4'b0000, 5, 20'h43210, 5'b00001, 5'b10000, 5'b0, 2'b00); // LDR
      add(32'hE5812000, 4'b0000, 4, 20'h05210, 5'b00001, 5'b0, 5'b01000, 2'b00); // STR
      add(32'h15812000, 4'b0000, 4, 20'h05210, 5'b00001, 5'b0, 5'b00000, 2'b00); // STRNE not
      add(32'hE591F000, 4'b0000, 5, 20'h43210, 5'b10001, 5'b10000, 5'b0, 2'b00); // LDR PC
      add(32'hEC000000, 4'b0000, 2, 20'h00010, 5'b00001, 5'b0, 5'b0, 2'b00);     // Op=11
      add(32'hF2801005, 4'b0000, 4, 20'h08710, 5'b00001, 5'b00000, 5'b0, 2'b00); // cond NV
      add(32'hE0812003, 4'b0000, 4, 20'h08610, 5'b00001, 5'b01000, 5'b0, 2'b00); // ADD reg
      add(32'hE281F004, 4'b0000, 4, 20'h08710, 5'b01001, 5'b01000, 5'b0, 2'b00); // ADD to PC
      add(32'hE0512003, 4'b0110, 4, 20'h08610, 5'b00001, 5'b01000, 5'b0, 2'b01); // SUBS -> N,V
      add(32'hAA000000, 4'b0000, 3, 20'h00910, 5'b00101, 5'b0, 5'b0, 2'b00);     // BGE taken
      add(32'h8A000000, 4'b0000, 3, 20'h00910, 5'b00001, 5'b0, 5'b0, 2'b00);     // BHI not

      // reset state: FETCH with all enables held off
      reset    = 1'b0;
      Instr    = '0;
      ALUflags = 4'b0000;
      repeat (2) @(negedge clk);
      check("reset_state", {16'd0, State}, 20'd0);
      check("reset_enables", {16'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 20'd0);
      reset = 1'b1;

      foreach (vecs[k])
         run_vec(vecs[k], $sformatf("vec%0d", k));

      // reset asserted in MEMWR
      Instr    = 20'hE5812;
      ALUflags = 4'b0000;
      repeat (3) @(negedge clk);
      #1;
      check("memwr_before_reset", {15'd0, State, MemWrite}, {15'd0, 4'd5, 1'b1});
      #2 reset = 1'b0;
      #1;
      check("memwr_reset_state", {16'd0, State}, 20'd0);
      check("memwr_reset_enables", {16'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 20'd0);
      @(negedge clk);
      check("reset_held_enables", {16'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 20'd0);
      reset = 1'b1;
      run_vec(vecs[0], "post_reset_add");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
